// File: rtl/oldland_mem_responder.sv
// Single-port word memory slave with fixed wait-state latency, byte-enable writes
// and error responses for out-of-range or read-only writes; accepts back-to-back requests.
module oldland_mem_responder #(
  parameter int mem_size    = 8192,
  parameter int wait_states = 1,
  parameter bit read_only   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m_access,
  input  logic [29:0] m_addr,
  input  logic        m_wr_en,
  input  logic [31:0] m_wr_val,
  input  logic [3:0]  m_bytesel,
  output logic [31:0] m_data,
  output logic        m_ack,
  output logic        m_error
);

  localparam int          WORDS   = mem_size / 4;
  localparam int          AW      = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [29:0] WORDS30 = 30'(WORDS);
  localparam logic [3:0]  WS4     = 4'(wait_states);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_next;
  logic [3:0]      cnt, cnt_next;
  logic            accept;
  logic            err_now;
  logic [AW-1:0]   m_idx;
  logic [AW-1:0]   addr_r;
  logic            wr_r;
  logic            err_r;
  logic [31:0]     rd_data;
  logic [31:0]     mem [WORDS] = '{default: 32'h0};

  assign accept  = m_access && !rst && (state != WAIT);
  assign err_now = (m_addr >= WORDS30) || (m_wr_en && read_only);
  assign m_idx   = m_addr[AW-1:0];

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE, RESP: begin
        if (accept) begin
          cnt_next   = WS4;
          state_next = (WS4 == 4'd0) ? RESP : WAIT;
        end else if (state == RESP) begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) state_next = RESP;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Request attributes captured at accept; only meaningful while in WAIT/RESP.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_r <= m_idx;
      wr_r   <= m_wr_en;
      err_r  <= err_now;
    end
  end

  // Writes commit at the accept edge, so a read accepted afterwards sees them.
  always_ff @(posedge clk) begin
    if (accept && m_wr_en && !err_now) begin
      for (int i = 0; i < 4; i++) begin
        if (m_bytesel[i]) mem[m_idx][8*i +: 8] <= m_wr_val[8*i +: 8];
      end
    end
    rd_data <= mem[accept ? m_idx : addr_r];
  end

  assign m_ack   = (state == RESP);
  assign m_error = m_ack && err_r;
  assign m_data  = (m_ack && !wr_r && !err_r) ? rd_data : 32'h0;

endmodule

// File: tb/tb_oldland_mem_responder.sv
// Bench for oldland_mem_responder: three instances (2 wait states; 0 wait states;
// 3 wait states read-only) driven by directed and random transactions against an array model.
module tb_oldland_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        access [3];
  logic [29:0] addr   [3];
  logic        wr     [3];
  logic [31:0] wval   [3];
  logic [3:0]  sel    [3];
  logic [2:0][31:0] rdata;
  logic [2:0]  ack;
  logic [2:0]  err;

  int          checks = 0;
  int          errors = 0;
  int          ws_of [3] = '{2, 0, 3};
  bit          ro_of [3] = '{1'b0, 1'b0, 1'b1};
  logic [31:0] mdl [3][2048];
  logic [31:0] last_data;

  always #5 clk = ~clk;

  oldland_mem_responder #(.mem_size(8192), .wait_states(2), .read_only(1'b0)) u_ws2 (
    .clk(clk), .rst(rst), .m_access(access[0]), .m_addr(addr[0]), .m_wr_en(wr[0]),
    .m_wr_val(wval[0]), .m_bytesel(sel[0]), .m_data(rdata[0]), .m_ack(ack[0]), .m_error(err[0]));

  oldland_mem_responder #(.mem_size(8192), .wait_states(0), .read_only(1'b0)) u_ws0 (
    .clk(clk), .rst(rst), .m_access(access[1]), .m_addr(addr[1]), .m_wr_en(wr[1]),
    .m_wr_val(wval[1]), .m_bytesel(sel[1]), .m_data(rdata[1]), .m_ack(ack[1]), .m_error(err[1]));

  oldland_mem_responder #(.mem_size(8192), .wait_states(3), .read_only(1'b1)) u_ro (
    .clk(clk), .rst(rst), .m_access(access[2]), .m_addr(addr[2]), .m_wr_en(wr[2]),
    .m_wr_val(wval[2]), .m_bytesel(sel[2]), .m_data(rdata[2]), .m_ack(ack[2]), .m_error(err[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nv,
                                        input logic [3:0] s);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = nv[8*i +: 8];
    return r;
  endfunction

  function automatic bit is_err(input int d, input logic [29:0] a, input logic w);
    return (a >= 30'd2048) || (w && ro_of[d]);
  endfunction

  // One complete transaction: hold access until ack, check latency and response.
  task automatic txn(input int d, input logic w, input logic [29:0] a,
                     input logic [31:0] v, input logic [3:0] s);
    bit          e = is_err(d, a, w);
    logic [31:0] exp_data = 32'h0;
    bit          got = 1'b0;
    int          lat = 0;
    if (!e && !w) exp_data = mdl[d][a[10:0]];
    if (!e && w) mdl[d][a[10:0]] = merge(mdl[d][a[10:0]], v, s);
    @(negedge clk);
    access[d] = 1'b1; wr[d] = w; addr[d] = a; wval[d] = v; sel[d] = s;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (ack[d]) begin
        got = 1'b1; lat = n;
        break;
      end
      chk("wait_zero", {rdata[d][31:1], rdata[d][0] | err[d]}, 32'h0);
    end
    access[d] = 1'b0;
    chk("ack_seen", 32'(got), 32'd1);
    chk("latency", 32'(lat), 32'(ws_of[d]));
    chk("error", 32'(err[d]), 32'(e));
    chk("data", rdata[d], exp_data);
    last_data = rdata[d];
  endtask

  // Accept a request, then assert rst in the next cycle; no ack may follow.
  task automatic rst_mid(input int d, input logic w, input logic [29:0] a, input logic [31:0] v);
    @(negedge clk);
    access[d] = 1'b1; wr[d] = w; addr[d] = a; wval[d] = v; sel[d] = 4'hF;
    @(posedge clk); #1;
    access[d] = 1'b0;
    if (w && !is_err(d, a, w)) mdl[d][a[10:0]] = v;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("rst_ack", 32'(ack[d]), 32'd0);
      chk("rst_out", {rdata[d][31:1], rdata[d][0] | err[d]}, 32'h0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [31:0] v;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      access[d] = 1'b0; addr[d] = '0; wr[d] = 1'b0; wval[d] = '0; sel[d] = '0;
      for (int i = 0; i < 2048; i++) mdl[d][i] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset_ack", 32'(ack[d]), 32'd0);
      chk("reset_err", 32'(err[d]), 32'd0);
      chk("reset_data", rdata[d], 32'h0);
    end
    rst = 1'b0;

    // Read latency with two wait states
    txn(0, 1'b1, 30'h10, 32'hDEADBEEF, 4'hF);
    txn(0, 1'b0, 30'h10, 32'h0, 4'h0);
    chk("deadbeef", last_data, 32'hDEADBEEF);

    // Byte-enable merge and empty byte mask
    txn(0, 1'b1, 30'h5, 32'h11223344, 4'hF);
    txn(0, 1'b1, 30'h5, 32'hAABBCCDD, 4'b0101);
    txn(0, 1'b0, 30'h5, 32'h0, 4'h0);
    chk("bytesel", last_data, 32'h11BB33DD);
    txn(0, 1'b1, 30'h5, 32'hFFFFFFFF, 4'b0000);
    txn(0, 1'b0, 30'h5, 32'h0, 4'h0);
    chk("bytesel_none", last_data, 32'h11BB33DD);

    // Out-of-range and read-only errors
    txn(0, 1'b0, 30'h800, 32'h0, 4'h0);
    txn(0, 1'b1, 30'h3FFFFFFF, 32'h12345678, 4'hF);
    txn(2, 1'b1, 30'h0, 32'hCAFEF00D, 4'hF);
    txn(2, 1'b0, 30'h0, 32'h0, 4'h0);
    chk("ro_read", last_data, 32'h0);

    // Pipelined line fill, zero wait states
    for (int i = 0; i < 8; i++) txn(1, 1'b1, 30'(32'h20 + i), $urandom, 4'hF);
    @(negedge clk);
    access[1] = 1'b1; wr[1] = 1'b0; addr[1] = 30'h20;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("fill_ack", 32'(ack[1]), 32'd1);
      chk("fill_data", rdata[1], mdl[1][32'h20 + i]);
      addr[1] = 30'(32'h21 + i);
    end
    access[1] = 1'b0;

    // Read accepted in the ack cycle of a write to the same word
    v = $urandom;
    @(negedge clk);
    access[1] = 1'b1; wr[1] = 1'b1; addr[1] = 30'h9; wval[1] = v; sel[1] = 4'b0110;
    mdl[1][9] = merge(mdl[1][9], v, 4'b0110);
    @(posedge clk); #1;
    chk("raw_wack", 32'(ack[1]), 32'd1);
    wr[1] = 1'b0;
    @(posedge clk); #1;
    chk("raw_rack", 32'(ack[1]), 32'd1);
    chk("raw_data", rdata[1], mdl[1][9]);
    access[1] = 1'b0;
    @(posedge clk); #1;
    chk("raw_idle", 32'(ack[1]), 32'd0);

    // Reset mid-operation; accepted writes stay committed
    rst_mid(2, 1'b0, 30'h4, 32'h0);
    txn(2, 1'b0, 30'h4, 32'h0, 4'h0);
    rst_mid(0, 1'b1, 30'h3, 32'h5A5AA5A5);
    txn(0, 1'b0, 30'h3, 32'h0, 4'h0);
    chk("wr_before_rst", last_data, 32'h5A5AA5A5);

    // Randomized traffic on all instances
    for (int k = 0; k < 90; k++) begin
      int          d = k % 3;
      logic [29:0] a;
      a = ($urandom_range(0, 9) == 0) ? 30'(2048 + $urandom_range(0, 300))
                                      : 30'($urandom_range(0, 31));
      txn(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
